// File: rtl/d16_pkg.sv
// Shared definitions for the d16 UART slave: register map, STATUS bit layout
// and the serial FSM state encodings.
package d16_pkg;

  localparam int unsigned UART_DW = 8;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;
  localparam logic [1:0] UART_DIV    = 2'd3;

  localparam int unsigned ST_RXNE   = 0;
  localparam int unsigned ST_TXFULL = 1;
  localparam int unsigned ST_TXIDLE = 2;
  localparam int unsigned ST_OVR    = 3;
  localparam int unsigned ST_FERR   = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAITHI
  } rx_state_e;

endpackage

// File: rtl/d16_fifo.sv
// Small synchronous FIFO. A push on a full FIFO is accepted only when a pop
// happens in the same cycle; head reads as zero while empty.
module d16_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == CW'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_head  = o_empty ? '0 : mem_q[rd_q];

  always_comb begin
    rd_d  = do_pop ? rd_q + AW'(1) : rd_q;
    wr_d  = do_push ? wr_q + AW'(1) : wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/d16_uart.sv
// Memory-mapped 8N1 UART slave for the d16 core bus: zero-wait reads,
// buffered TX/RX through two FIFOs, registered interrupt request.
module d16_uart
  import d16_pkg::*;
#(
  parameter logic [15:0] BASE       = 16'hFF00,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_wb_addr,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [15:0] i_wb_dat,
  output logic [15:0] o_wb_dat,
  output logic        o_sel,
  output logic        o_int,
  input  logic        i_rx,
  output logic        o_tx
);

  logic [1:0]         off;
  logic               rd, wr, tx_idle, line;
  logic               tx_push, tx_pop, tx_empty, tx_full;
  logic               rx_push, rx_pop, rx_empty, rx_full;
  logic [UART_DW-1:0] tx_head, rx_head;
  logic [15:0]        div_m1, half, half_m1;

  logic [1:0]         ctrl_q, ctrl_d;
  logic [15:0]        div_q, div_d;
  logic               ovr_q, ovr_d, ferr_q, ferr_d, int_q, int_d;
  tx_state_e          tx_state_q, tx_state_d;
  logic [15:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]         tx_bit_q, tx_bit_d;
  logic [UART_DW-1:0] tx_shift_q, tx_shift_d;
  logic               tx_out_q, tx_out_d;
  logic [1:0]         sync_q, sync_d;
  logic               rx_prev_q, rx_prev_d;
  rx_state_e          rx_state_q, rx_state_d;
  logic [15:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]         rx_bit_q, rx_bit_d;
  logic [UART_DW-1:0] rx_shift_q, rx_shift_d;

  assign o_sel   = i_wb_cyc && (i_wb_addr[15:2] == BASE[15:2]);
  assign off     = i_wb_addr[1:0];
  assign rd      = o_sel && !i_wb_we;
  assign wr      = o_sel && i_wb_we;
  assign tx_push = wr && (off == UART_DATA);
  assign rx_pop  = rd && (off == UART_DATA);
  assign tx_idle = tx_empty && (tx_state_q == TX_IDLE);
  assign line    = sync_q[1];
  assign div_m1  = div_q - 16'd1;
  assign half    = {1'b0, div_q[15:1]};
  assign half_m1 = (half == 16'd0) ? 16'd0 : half - 16'd1;
  assign o_tx    = tx_out_q;
  assign o_int   = int_q;

  d16_fifo #(.WIDTH(UART_DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(tx_push), .i_pop(tx_pop),
    .i_din(i_wb_dat[UART_DW-1:0]), .o_head(tx_head), .o_empty(tx_empty), .o_full(tx_full)
  );

  d16_fifo #(.WIDTH(UART_DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(i_clk), .i_reset(i_reset), .i_push(rx_push), .i_pop(rx_pop),
    .i_din(rx_shift_q), .o_head(rx_head), .o_empty(rx_empty), .o_full(rx_full)
  );

  // Zero-wait read mux
  always_comb begin
    o_wb_dat = 16'd0;
    if (rd) begin
      case (off)
        UART_DATA:   o_wb_dat = {7'd0, !rx_empty, rx_head};
        UART_STATUS: o_wb_dat = {11'd0, ferr_q, ovr_q, tx_idle, tx_full, !rx_empty};
        UART_CTRL:   o_wb_dat = {14'd0, ctrl_q};
        default:     o_wb_dat = div_q;
      endcase
    end
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    div_d      = div_q;
    ovr_d      = ovr_q;
    ferr_d     = ferr_q;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    tx_pop     = 1'b0;
    sync_d     = {sync_q[0], i_rx};
    rx_prev_d  = line;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;

    // Sticky clears come first so a same-cycle set below wins
    if (wr) begin
      case (off)
        UART_STATUS: begin
          if (i_wb_dat[ST_OVR])  ovr_d  = 1'b0;
          if (i_wb_dat[ST_FERR]) ferr_d = 1'b0;
        end
        UART_CTRL: ctrl_d = i_wb_dat[1:0];
        UART_DIV:  div_d  = (i_wb_dat == 16'd0) ? 16'd1 : i_wb_dat;
        default: ;
      endcase
    end

    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_out_d   = 1'b0;
          tx_cnt_d   = div_m1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_out_d   = tx_shift_q[0];
          tx_cnt_d   = div_m1;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = div_m1;
          if (tx_bit_q == 3'd7) begin
            tx_out_d   = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[UART_DW-1:1]};
            tx_out_d   = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: begin
        if (tx_cnt_q == 16'd0) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_out_d   = 1'b0;
            tx_cnt_d   = div_m1;
            tx_state_d = TX_START;
          end else tx_state_d = TX_IDLE;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
    endcase

    // Receiver samples mid-bit: half a period after the start edge, then every period
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !line) begin
          rx_cnt_d   = half_m1;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (!line) begin
            rx_cnt_d   = div_m1;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end else rx_state_d = RX_IDLE;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {line, rx_shift_q[UART_DW-1:1]};
          rx_cnt_d   = div_m1;
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          if (line) begin
            rx_push    = 1'b1;
            if (rx_full && !rx_pop) ovr_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            ferr_d     = 1'b1;
            rx_state_d = RX_WAITHI;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_WAITHI: if (line) rx_state_d = RX_IDLE;
      default:   rx_state_d = RX_IDLE;
    endcase

    int_d = (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_idle);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q     <= 2'd0;
      div_q      <= DIV_RESET;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      int_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= '0;
      tx_out_q   <= 1'b1;
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      int_q      <= int_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_out_q   <= tx_out_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_d16_uart.sv
// Self-checking bench for d16_uart: bus register access, TX/RX framing at
// DIV=4, overrun, frame error, glitch rejection, interrupts and async reset.
module tb_d16_uart;
  import d16_pkg::*;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam int unsigned BIT  = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_wb_addr = 16'd0;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_we = 1'b0;
  logic [15:0] i_wb_dat = 16'd0;
  logic [15:0] o_wb_dat;
  logic        o_sel, o_int, o_tx;
  logic        i_rx = 1'b1;

  int total = 0;
  int bad   = 0;
  logic [7:0] rx_sb[$];
  logic [7:0] tx_sb[$];

  d16_uart #(.BASE(BASE), .FIFO_DEPTH(4), .DIV_RESET(16'd434)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_wb_addr(i_wb_addr), .i_wb_cyc(i_wb_cyc),
    .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat), .o_wb_dat(o_wb_dat), .o_sel(o_sel),
    .o_int(o_int), .i_rx(i_rx), .o_tx(o_tx)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] off, input logic [15:0] d);
    @(negedge i_clk);
    i_wb_addr = BASE | 16'(off);
    i_wb_cyc  = 1'b1;
    i_wb_we   = 1'b1;
    i_wb_dat  = d;
    @(posedge i_clk);
    #1;
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] off, output logic [15:0] d);
    @(negedge i_clk);
    i_wb_addr = BASE | 16'(off);
    i_wb_cyc  = 1'b1;
    i_wb_we   = 1'b0;
    #1;
    d = o_wb_dat;
    @(posedge i_clk);
    #1;
    i_wb_cyc = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] off, input logic [15:0] exp);
    logic [15:0] d;
    bus_rd(off, d);
    check_val(tag, d, exp);
  endtask

  // Pops the RX scoreboard; an empty scoreboard means the DATA read must return 0
  task automatic rd_data(input string tag);
    logic [15:0] d, exp;
    bus_rd(UART_DATA, d);
    exp = 16'd0;
    if (rx_sb.size() > 0) exp = {7'd0, 1'b1, rx_sb.pop_front()};
    check_val(tag, d, exp);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input logic keep);
    if (keep) rx_sb.push_back(b);
    @(negedge i_clk);
    i_rx = 1'b0;
    repeat (BIT) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (BIT) @(negedge i_clk);
    end
    i_rx = stop;
    repeat (BIT) @(negedge i_clk);
    i_rx = 1'b1;
  endtask

  // Decodes one frame from o_tx, sampling the middle of every bit
  task automatic tx_watch();
    logic [7:0] got, exp;
    int n;
    n = 0;
    got = 8'd0;
    while (o_tx !== 1'b0 && n < 20) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (o_tx !== 1'b0) begin
      check_val("tx_start_seen", 16'(o_tx), 16'd0);
    end else begin
      repeat (2) @(posedge i_clk);
      #1;
      check_val("tx_start", 16'(o_tx), 16'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(posedge i_clk);
        #1;
        got[i] = o_tx;
      end
      repeat (BIT) @(posedge i_clk);
      #1;
      check_val("tx_stop", 16'(o_tx), 16'd1);
      exp = 8'd0;
      if (tx_sb.size() > 0) exp = tx_sb.pop_front();
      check_val("tx_byte", 16'(got), 16'(exp));
    end
  endtask

  task automatic tx_send(input logic [7:0] b);
    tx_sb.push_back(b);
    bus_wr(UART_DATA, {8'd0, b});
    tx_watch();
    repeat (3) @(posedge i_clk);
    rd_check("tx_idle_after", UART_STATUS, 16'h0004);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check_val("rst_tx_held", 16'(o_tx), 16'd1);
    @(negedge i_clk);
    i_reset = 1'b0;

    rd_check("rst_status", UART_STATUS, 16'h0004);
    rd_check("rst_div", UART_DIV, 16'd434);
    rd_check("rst_ctrl", UART_CTRL, 16'h0000);
    check_val("rst_tx", 16'(o_tx), 16'd1);
    check_val("rst_int", 16'(o_int), 16'd0);

    // Address decode
    @(negedge i_clk);
    i_wb_addr = 16'hFE01;
    i_wb_cyc  = 1'b1;
    #1;
    check_val("unsel_dat", o_wb_dat, 16'd0);
    check_val("unsel_sel", 16'(o_sel), 16'd0);
    i_wb_addr = BASE | 16'd3;
    #1;
    check_val("sel_hit", 16'(o_sel), 16'd1);
    @(posedge i_clk);
    #1;
    i_wb_cyc = 1'b0;

    bus_wr(UART_DIV, 16'd0);
    rd_check("div_zero", UART_DIV, 16'd1);
    bus_wr(UART_DIV, 16'd4);
    rd_check("div_four", UART_DIV, 16'd4);

    tx_send(8'hA5);
    tx_send(8'h3E);

    rx_frame(8'h3C, 1'b1, 1'b1);
    repeat (4) @(negedge i_clk);
    rd_check("rx_status", UART_STATUS, 16'h0005);
    rd_data("rx_data");
    rd_data("rx_empty_read");

    // Five frames into a four-deep FIFO: the last is dropped
    for (int i = 0; i < 5; i++) rx_frame(8'h10 + 8'(i * 17), 1'b1, i < 4);
    repeat (4) @(negedge i_clk);
    rd_check("ovr_status", UART_STATUS, 16'h000D);
    repeat (4) rd_data("ovr_data");
    rd_check("ovr_drained", UART_STATUS, 16'h000C);
    bus_wr(UART_STATUS, 16'h0008);
    rd_check("ovr_clear", UART_STATUS, 16'h0004);

    rx_frame(8'h81, 1'b0, 1'b0);
    repeat (4) @(negedge i_clk);
    rd_check("ferr_status", UART_STATUS, 16'h0014);
    bus_wr(UART_STATUS, 16'h0010);
    rd_check("ferr_clear", UART_STATUS, 16'h0004);

    @(negedge i_clk);
    i_rx = 1'b0;
    @(negedge i_clk);
    i_rx = 1'b1;
    repeat (12) @(negedge i_clk);
    rd_check("glitch_status", UART_STATUS, 16'h0004);

    bus_wr(UART_CTRL, 16'h0001);
    repeat (2) @(posedge i_clk);
    #1;
    check_val("int_quiet", 16'(o_int), 16'd0);
    rx_frame(8'h55, 1'b1, 1'b1);
    repeat (4) @(negedge i_clk);
    #1;
    check_val("int_rx", 16'(o_int), 16'd1);
    rd_data("int_data");
    check_val("int_hold", 16'(o_int), 16'd1);
    @(posedge i_clk);
    #1;
    check_val("int_clr", 16'(o_int), 16'd0);

    bus_wr(UART_CTRL, 16'h0002);
    check_val("int_txidle_lat", 16'(o_int), 16'd0);
    @(posedge i_clk);
    #1;
    check_val("int_txidle", 16'(o_int), 16'd1);
    rd_check("ctrl_rd", UART_CTRL, 16'h0002);

    // Reset in the middle of a frame forces the line high at once
    bus_wr(UART_CTRL, 16'h0000);
    bus_wr(UART_DATA, 16'h0000);
    repeat (10) @(posedge i_clk);
    #1;
    check_val("tx_mid", 16'(o_tx), 16'd0);
    #2;
    i_reset = 1'b1;
    #1;
    check_val("rst_async_tx", 16'(o_tx), 16'd1);
    @(negedge i_clk);
    i_reset = 1'b0;
    rd_check("rst2_div", UART_DIV, 16'd434);
    rd_check("rst2_status", UART_STATUS, 16'h0004);
    check_val("rst2_int", 16'(o_int), 16'd0);
    check_val("rst2_tx", 16'(o_tx), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
